down_counter32: RTL and testbench



---
 rtl/down_counter32.sv | 64 ++++++
 tb/tb_down_counter32.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/down_counter32.sv
// down_counter32: loadable down-counter/timer, one-shot or auto-reload (DOWN_COUNTER32_AUTORELOAD_EN)
module down_counter32 #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             SRST,
  input  logic             Load_i,
  input  logic [WIDTH-1:0] Preset_i,
  input  logic             Enable_i,
  output logic [WIDTH-1:0] Count_o,
  output logic             Zero_o,
  output logic             Running_o,
  output logic             Expired_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_EXP  = 2'd2;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_running;
  logic             r_expired;
  logic             w_dec;
  logic             w_last;
  logic [1:0]       w_state_nx;
  logic [WIDTH-1:0] w_count_nx;
  logic [WIDTH-1:0] w_wrap;
`ifdef DOWN_COUNTER32_AUTORELOAD_EN
  logic [WIDTH-1:0] r_reload;
  // reload register captures every preset so expiry can restart the period
  always_ff @(posedge CLK)
    if (SRST) r_reload <= RESET_VALUE;
    else if (Load_i) r_reload <= Preset_i;
  assign w_wrap = r_reload;
  localparam logic [1:0] S_AFTER = S_RUN;
`else
  assign w_wrap = '0;
  localparam logic [1:0] S_AFTER = S_EXP;
`endif
  // next-state decode; load beats decrement, so a load on the expiry edge suppresses the pulse
  always_comb begin
    w_dec      = (r_state == S_RUN) && Enable_i && (r_count != '0);
    w_last     = w_dec && (r_count == WIDTH'(1));
    w_state_nx = Load_i ? ((Preset_i != '0) ? S_RUN : S_IDLE) : (w_last ? S_AFTER : r_state);
    w_count_nx = Load_i ? Preset_i : (w_last ? w_wrap : (w_dec ? r_count - WIDTH'(1) : r_count));
  end
  // registered state, count and status flags
  always_ff @(posedge CLK)
    if (SRST) begin
      r_state   <= S_IDLE;
      r_count   <= RESET_VALUE;
      r_running <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_count   <= w_count_nx;
      r_running <= (w_state_nx == S_RUN);
      r_expired <= !Load_i && w_last;
    end
  assign Count_o   = r_count;
  assign Zero_o    = (r_count == '0);
  assign Running_o = r_running;
  assign Expired_o = r_expired;
endmodule

// File: tb/tb_down_counter32.sv
// tb_down_counter32: directed self-checking bench for down_counter32
module tb_down_counter32;
  logic        clk = 1'b0;
  logic        srst = 1'b0;
  logic        load = 1'b0;
  logic [31:0] preset = '0;
  logic        en = 1'b0;
  logic [31:0] count;
  logic        zero;
  logic        running;
  logic        expired;
  int vectors = 0;
  int errors = 0;

  down_counter32 dut (
    .CLK(clk), .SRST(srst), .Load_i(load), .Preset_i(preset), .Enable_i(en),
    .Count_o(count), .Zero_o(zero), .Running_o(running), .Expired_o(expired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b1; load = 1'b0; en = 1'b0;
    tick();
    srst = 1'b0;
    vectors++;
    if ({count, zero, running, expired} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: count=%h zero=%b run=%b exp=%b, want 0 1 0 0", count, zero, running, expired);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] ec [4] = '{32'd3, 32'd2, 32'd1, 32'd0};
    logic        ee [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        er [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    load = 1'b1; preset = 32'd3; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      load = 1'b0;
      vectors++;
      if ({count, expired, running} !== {ec[i], ee[i], er[i]}) begin
        errors++;
        $display("FAIL oneshot[%0d]: count=%h exp=%b run=%b, want %h %b %b", i, count, expired, running, ec[i], ee[i], er[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({count, zero, expired, running} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL oneshot_hold[%0d]: count=%h zero=%b exp=%b run=%b, want 0 1 0 0", i, count, zero, expired, running);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_enable_gating();
    logic [31:0] ec [5] = '{32'd5, 32'd4, 32'd4, 32'd3, 32'd3};
    logic        ev [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    load = 1'b1; preset = 32'd5; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      load = 1'b0;
      vectors++;
      if ({count, expired, running} !== {ec[i], 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL enable_gating[%0d]: count=%h exp=%b run=%b, want %h 0 1", i, count, expired, running, ec[i]);
      end
      en = ev[i];
    end
  endtask

  task automatic test_load_wins();
    en = 1'b1;
    tick();
    tick();
    vectors++;
    if (count !== 32'd1) begin
      errors++;
      $display("FAIL load_wins_pre: count=%h, want 1", count);
    end
    load = 1'b1; preset = 32'h0000_0010;
    tick();
    load = 1'b0; en = 1'b0;
    vectors++;
    if ({count, expired, running} !== {32'h10, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL load_wins: count=%h exp=%b run=%b, want 10 0 1", count, expired, running);
    end
  endtask

  task automatic test_reset_abort();
    load = 1'b1; preset = 32'hFFFF_FFFF; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    tick();
    vectors++;
    if ({count, running} !== {32'hFFFF_FFFD, 1'b1}) begin
      errors++;
      $display("FAIL abort_pre: count=%h run=%b, want fffffffd 1", count, running);
    end
    srst = 1'b1; load = 1'b1; preset = 32'd7;
    tick();
    srst = 1'b0; load = 1'b0;
    vectors++;
    if ({count, zero, expired, running} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort: count=%h zero=%b exp=%b run=%b, want 0 1 0 0", count, zero, expired, running);
    end
    tick();
    vectors++;
    if ({count, expired, running} !== {32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_idle: count=%h exp=%b run=%b, want 0 0 0", count, expired, running);
    end
    en = 1'b0;
  endtask

  task automatic test_load_zero();
    load = 1'b1; preset = 32'd9;
    tick();
    load = 1'b1; preset = 32'd0; en = 1'b1;
    tick();
    load = 1'b0;
    vectors++;
    if ({count, zero, expired, running} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load_zero: count=%h zero=%b exp=%b run=%b, want 0 1 0 0", count, zero, expired, running);
    end
    tick();
    vectors++;
    if ({count, expired} !== {32'h0, 1'b0}) begin
      errors++;
      $display("FAIL load_zero_idle: count=%h exp=%b, want 0 0", count, expired);
    end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    load = 1'b1; preset = 32'd1; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    vectors++;
    if ({count, expired, running} !== {32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_first: count=%h exp=%b run=%b, want 0 1 0", count, expired, running);
    end
    load = 1'b1;
    tick();
    load = 1'b0;
    vectors++;
    if ({count, expired, running} !== {32'h1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_rearm: count=%h exp=%b run=%b, want 1 0 1", count, expired, running);
    end
    tick();
    vectors++;
    if ({count, expired, running} !== {32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second: count=%h exp=%b run=%b, want 0 1 0", count, expired, running);
    end
    en = 1'b0;
  endtask

  task automatic test_autoreload();
    logic [31:0] ec [6] = '{32'd1, 32'd2, 32'd1, 32'd2, 32'd1, 32'd2};
    logic        ee [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    load = 1'b1; preset = 32'd2; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    vectors++;
    if ({count, running} !== {32'd2, 1'b1}) begin
      errors++;
      $display("FAIL autoreload_load: count=%h run=%b, want 2 1", count, running);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if ({count, expired, running} !== {ec[i], ee[i], 1'b1}) begin
        errors++;
        $display("FAIL autoreload[%0d]: count=%h exp=%b run=%b, want %h %b 1", i, count, expired, running, ec[i], ee[i]);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
`ifdef DOWN_COUNTER32_AUTORELOAD_EN
    test_autoreload();
`else
    test_oneshot();
    test_back_to_back();
`endif
    test_enable_gating();
    test_load_wins();
    test_reset_abort();
    test_load_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
